datapath_soma_serial: RTL
=========================

Name: datapath_soma_serial

Overview:
- Datapath driven by the sequencing controller's one-hot enables (HabRegAB, HabRegS, LoadDesloca, Desloca, HabRegFim).
- Registers operands A and B, forms their sum with carry, and loads the sum into a shift register.
- Shifts the sum out serially LSB-first, reassembles the bits, and latches the rebuilt word as the final result.
- Sits directly downstream of the controller FSM and consumes its control outputs one-for-one.

Parameters:
- WIDTH, 4, operand width in bits. Sum, shift and final registers are WIDTH+1 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- HabRegAB  input  1  load operand registers
- HabRegS  input  1  load sum register
- LoadDesloca  input  1  load shift register from sum register
- Desloca  input  1  shift-enable
- HabRegFim  input  1  enable final-result capture
- serial_out  output  1  last bit shifted out (registered)
- soma  output  WIDTH+1  sum register contents
- resultado_fim  output  WIDTH+1  reassembled final result
- bit_count  output  clog2(WIDTH+2)  shifts performed since last load
- done  output  1  final result valid; sticky until next LoadDesloca or rst

Behaviour:
- Reset: one clock; synchronous, active-high reset.
  - rst high at a rising edge clears every register: regA, regB, soma, shift reg, accumulator, resultado_fim, serial_out, bit_count, done all 0; state IDLE.
  - rst overrides all enables, including mid-shift.
- Operand load: HabRegAB=1 -> regA<=a_in, regB<=b_in at that edge. Otherwise hold.
- Sum: HabRegS=1 -> soma <= {1'b0,regA}+{1'b0,regB}.
  - Full WIDTH+1 result; carry kept in MSB; no wrap.
  - Uses register values from before the edge, not a_in/b_in.
- State machine (internal): IDLE, CARREGADO, DESLOCANDO, CONCLUIDO.
  - Any state with LoadDesloca=1:
    - shift <= soma, acc <= 0, bit_count <= 0, done <= 0, serial_out <= 0.
    - Next state CARREGADO.
    - LoadDesloca has priority over Desloca and HabRegFim in the same cycle.
  - CARREGADO or DESLOCANDO with Desloca=1 and bit_count < WIDTH+1:
    - serial_out <= shift[0]
    - shift <= {1'b0, shift[WIDTH:1]}
    - acc <= {shift[0], acc[WIDTH:1]}
    - bit_count++
    - Next state DESLOCANDO.
  - Desloca=0: hold all shift state.
  - bit_count==WIDTH+1: further Desloca ignored (saturate; no counter wrap; shift and acc frozen).
  - DESLOCANDO with bit_count==WIDTH+1 and HabRegFim=1:
    - resultado_fim <= acc, done <= 1.
    - Next state CONCLUIDO.
  - HabRegFim before all WIDTH+1 shifts complete: ignored; resultado_fim unchanged.
  - CONCLUIDO: holds. Continuous Desloca/HabRegFim (controller parked in its final state) cause no change. Only LoadDesloca or rst leave CONCLUIDO.
  - Desloca in IDLE (never loaded): ignored.
- Latency, with Desloca and HabRegFim held high from the cycle Desloca first rises:
  - WIDTH+1 edges perform the shifts.
  - The next edge captures the result.
  - done is high after the (WIDTH+2)th edge counted from the first Desloca edge.
- Invariant: when done=1, resultado_fim == soma value loaded at the last LoadDesloca.
- HabRegAB/HabRegS during shifting: regA/regB/soma update normally; the shift in progress is unaffected (shift reg holds its own copy).
- Simultaneous HabRegAB and HabRegS: soma uses old regA/regB.

Test Plan (WIDTH=4):
- Controller sequence, a_in=9, b_in=12, one enable per cycle, then Desloca+HabRegFim held:
  - soma=5'b10101 (21)
  - serial_out over 5 shift cycles = 1,0,1,0,1
  - bit_count 1..5
  - done=1 and resultado_fim=21 after the 6th Desloca edge; stays there 10 further cycles.
- Overflow, a_in=15, b_in=15: soma=30 (5'b11110), serial 0,1,1,1,1, resultado_fim=30, done=1.
- Reset mid-shift: after 2 shifts assert rst one cycle -> all outputs 0, state IDLE. Subsequent Desloca alone has no effect (bit_count stays 0).
- Reload priority:
  - In CONCLUIDO, drive LoadDesloca and Desloca together -> done=0, bit_count=0, shift=soma; no shift that cycle.
  - Re-run with a_in=3, b_in=4 -> resultado_fim=7.
- Early HabRegFim: pulse HabRegFim after 3 shifts -> resultado_fim unchanged, done=0. Complete the shifts with HabRegFim high -> captured correctly.
- Saturation: 12 consecutive Desloca after load -> bit_count stops at 5, serial_out holds its last value, no wrap.

Source files
------------

// File: rtl/datapath_soma_serial_if.sv
// Bus between the sequencing controller and the serial-sum datapath.
// Carries the operands, the controller's one-hot enables and the datapath results.
//   master : controller side, drives operands and enables, observes results
//   slave  : datapath side, consumes operands and enables, drives results
interface datapath_soma_serial_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             HabRegAB;
    logic             HabRegS;
    logic             LoadDesloca;
    logic             Desloca;
    logic             HabRegFim;
    logic             serial_out;
    logic [WIDTH:0]   soma;
    logic [WIDTH:0]   resultado_fim;
    logic [CW-1:0]    bit_count;
    logic             done;

    modport master (
        output a_in, b_in, HabRegAB, HabRegS, LoadDesloca, Desloca, HabRegFim,
        input  serial_out, soma, resultado_fim, bit_count, done
    );

    modport slave (
        input  a_in, b_in, HabRegAB, HabRegS, LoadDesloca, Desloca, HabRegFim,
        output serial_out, soma, resultado_fim, bit_count, done
    );
endinterface

// File: rtl/datapath_soma_serial.sv
// Serial-sum datapath: registers A and B, forms the WIDTH+1 bit sum, shifts it
// out LSB-first, reassembles the bits and latches the rebuilt word.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides every enable
//   bus  : slave side of datapath_soma_serial_if (operands, enables, results)
module datapath_soma_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    datapath_soma_serial_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CARREGADO,
        DESLOCANDO,
        CONCLUIDO
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH:0]   somaReg;
    logic [WIDTH:0]   shiftReg;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   resultadoReg;
    logic [CW-1:0]    bitCount;
    logic             serialReg;
    logic             doneReg;

    // Operand/sum registers run independently of the shifter, which keeps its own copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            regA         <= '0;
            regB         <= '0;
            somaReg      <= '0;
            shiftReg     <= '0;
            acc          <= '0;
            resultadoReg <= '0;
            bitCount     <= '0;
            serialReg    <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            if (bus.HabRegAB) begin
                regA <= bus.a_in;
                regB <= bus.b_in;
            end
            // Right-hand side sees pre-edge regA/regB, so a simultaneous HabRegAB uses old operands.
            if (bus.HabRegS) begin
                somaReg <= {1'b0, regA} + {1'b0, regB};
            end

            if (bus.LoadDesloca) begin
                shiftReg  <= somaReg;
                acc       <= '0;
                bitCount  <= '0;
                doneReg   <= 1'b0;
                serialReg <= 1'b0;
                state     <= CARREGADO;
            end else begin
                case (state)
                    CARREGADO, DESLOCANDO: begin
                        if (bus.Desloca && (bitCount != LAST_COUNT)) begin
                            serialReg <= shiftReg[0];
                            shiftReg  <= {1'b0, shiftReg[WIDTH:1]};
                            acc       <= {shiftReg[0], acc[WIDTH:1]};
                            bitCount  <= bitCount + CW'(1);
                            state     <= DESLOCANDO;
                        end else if ((state == DESLOCANDO) && (bitCount == LAST_COUNT)
                                     && bus.HabRegFim) begin
                            resultadoReg <= acc;
                            doneReg      <= 1'b1;
                            state        <= CONCLUIDO;
                        end
                    end
                    // Parked until the next reload; Desloca before any load is ignored.
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.serial_out    = serialReg;
    assign bus.soma          = somaReg;
    assign bus.resultado_fim = resultadoReg;
    assign bus.bit_count     = bitCount;
    assign bus.done          = doneReg;
endmodule
